// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing and line levels.
// Used by uart_tx (and later uart_rx).
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 143;
    localparam int unsigned DATA_BITS_DEFAULT    = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity bit over a full payload byte.
    function automatic logic even_parity(input logic [DATA_BITS_DEFAULT-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side byte handshake for uart_tx (data/valid in, ready/busy out).
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 ready;
    logic                 busy;

    modport master (output data, output data_valid, input ready, input busy);
    modport slave  (input data, input data_valid, output ready, output busy);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and raises a registered one-cycle
// tick_o while the counter sits at its terminal count. clr_i holds it at zero.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 143
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tick is predicted from the next count so it is high exactly while cnt_q == LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, LSB first, idle-high registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx
);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 tick;
    logic                 baud_clr_c;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    // Baud counter idles at zero, so every frame starts on a fresh bit period.
    assign baud_clr_c = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (baud_clr_c),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= STOP_BIT;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= STOP_BIT;
                    if (bus.data_valid && ready_q) begin
                        shift_q <= bus.data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^bus.data;
`endif
                        tx_q    <= START_BIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= STOP_BIT;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            tx_q      <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_q    <= STOP_BIT;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= STOP_BIT;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 143 clocks per bit; frame vectors are hand-written.
// Also builds with UART_TX_PARITY_EN defined (11-bit frames).
module tb_uart_tx;
    localparam int unsigned CPB = 143;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic [0:7] seq;    // line levels of the data bits in transmit order
        logic       par;    // even parity, hand-computed
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_tx_if #(.DATA_BITS(8)) bus ();

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [0:NBITS-1] mk_lvl(input vec_t v);
        logic [0:NBITS-1] l;
        l = '1;
        l[0] = 1'b0;
        for (int i = 0; i < 8; i++) l[i+1] = v.seq[i];
`ifdef UART_TX_PARITY_EN
        l[9] = v.par;
`endif
        l[NBITS-1] = 1'b1;
        return l;
    endfunction

    task automatic wait_ready(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: ready timeout, got 0, expected 1", name);
    endtask

    // Called right after the accept edge; checks the whole frame cycle by cycle.
    task automatic capture(input vec_t v, input string name);
        logic [0:NBITS-1] lvl;
        logic [7:0]       dec;
        int               e_tx;
        int               e_rb;
        int               p;
        lvl  = mk_lvl(v);
        dec  = '0;
        e_tx = 0;
        e_rb = 0;
        for (int c = 0; c < int'(NBITS * CPB); c++) begin
            @(negedge clk);
            p = c / int'(CPB);
            if (tx !== lvl[p]) e_tx++;
            if (bus.ready !== 1'b0 || bus.busy !== 1'b1) e_rb++;
            if ((c % int'(CPB)) == int'(CPB / 2) && p >= 1 && p <= 8) dec[p-1] = tx;
        end
        check({name, " tx waveform errors"}, 32'(e_tx), 32'd0);
        check({name, " ready/busy in frame errors"}, 32'(e_rb), 32'd0);
        check({name, " decoded byte"}, 32'(dec), 32'(v.data));
        @(negedge clk);
        check({name, " post-frame {tx,ready,busy}"}, 32'({tx, bus.ready, bus.busy}), 32'b110);
    endtask

    task automatic send(input vec_t v, input string name);
        wait_ready(name);
        bus.data       = v.data;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.data       = ~v.data;
        capture(v, name);
    endtask

    task automatic reset_mid(input int period, input logic exp_lvl, input string name);
        int e;
        wait_ready(name);
        bus.data       = 8'h0F;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        repeat (period * int'(CPB) + int'(CPB / 2)) @(negedge clk);
        check({name, " tx before reset"}, 32'(tx), 32'(exp_lvl));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({name, " {tx,ready,busy} after reset"}, 32'({tx, bus.ready, bus.busy}), 32'b110);
        e = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.ready !== 1'b1) e++;
        end
        check({name, " line stays idle"}, 32'(e), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int e;
        int cnt;
        int run;

        vecs[0] = '{data: 8'hA5, seq: 8'b10100101, par: 1'b0};
        vecs[1] = '{data: 8'h57, seq: 8'b11101010, par: 1'b1};
        vecs[2] = '{data: 8'h00, seq: 8'b00000000, par: 1'b0};
        vecs[3] = '{data: 8'hFF, seq: 8'b11111111, par: 1'b0};
        vecs[4] = '{data: 8'h07, seq: 8'b11100000, par: 1'b1};

        bus.data       = 8'h00;
        bus.data_valid = 1'b0;

        // Reset and idle
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset {tx,ready,busy}", 32'({tx, bus.ready, bus.busy}), 32'b110);
        rst = 1'b0;
        e = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0) e++;
        end
        check("idle 500 cycles errors", 32'(e), 32'd0);

        // Table of single frames
        foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with data_valid held high: 0x00 then 0xFF
        wait_ready("b2b");
        bus.data       = 8'h00;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data = 8'hFF;
        cnt = 0;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cnt++;
            run = (tx === 1'b1) ? run + 1 : 0;
            if (bus.ready === 1'b1) break;
        end
        check("b2b accept spacing", 32'(cnt), 32'(NBITS * CPB + 1));
        check("b2b high cycles between frames", 32'(run), 32'(CPB + 1));
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.data       = 8'h3C;
        capture(vecs[3], "b2b second");

        // Reset mid-frame: data bit 3 (high) and data bit 4 (low) of 0x0F
        reset_mid(4, 1'b1, "rst bit3");
        reset_mid(5, 1'b0, "rst bit4");

        // Reset and data_valid on the same edge
        @(negedge clk);
        rst            = 1'b1;
        bus.data       = 8'h55;
        bus.data_valid = 1'b1;
        @(negedge clk);
        check("rst+valid {tx,ready,busy}", 32'({tx, bus.ready, bus.busy}), 32'b110);
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        e = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0) e++;
        end
        check("rst+valid no frame", 32'(e), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
